// File: rtl/remote_arbiter.sv
// Round-robin arbiter granting one of NUM_CORES cores access to the shared memory/device bus,
// with optional bounded bus locking and a one-cycle registered read-return tag.
module remote_arbiter #(
   parameter int NUM_CORES = 8,
   parameter int LOCK_MAX  = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_CORES-1:0]    req_wren,
   input  logic [NUM_CORES-1:0]    req_rden,
   input  logic [NUM_CORES-1:0]    req_lock,
   input  logic [16*NUM_CORES-1:0] req_addr,
   input  logic [16*NUM_CORES-1:0] req_write_val,
   output logic [NUM_CORES-1:0]    grant,
   output logic                    mem_wren,
   output logic                    mem_rden,
   output logic [15:0]             mem_addr,
   output logic [15:0]             mem_write_val,
   output logic [2:0]              mem_core_id,
   output logic                    rd_valid,
   output logic [2:0]              rd_core_id
);

   // state     | meaning
   // ST_IDLE   | round-robin arbitration among all requesters
   // ST_LOCKED | bus reserved for r_owner; lock_count bounds the hold time

   localparam int              CW         = $clog2(LOCK_MAX + 1);
   localparam logic [2:0]      IDX_MASK   = 3'(NUM_CORES - 1);
   localparam logic [CW-1:0]   LOCK_MAX_C = CW'(LOCK_MAX);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   lock_state_t          r_state;
   lock_state_t          w_state_nxt;
   logic [2:0]           r_last_grant;
   logic [2:0]           w_last_grant_nxt;
   logic [2:0]           r_owner;
   logic [2:0]           w_owner_nxt;
   logic [CW-1:0]        r_lock_count;
   logic [CW-1:0]        w_lock_count_nxt;
   logic                 r_no_relock;
   logic                 w_no_relock_nxt;
   logic [NUM_CORES-1:0] w_req;
   logic                 w_found;
   logic [2:0]           w_sel;
   logic                 w_sel_lock;

   assign w_req = req_wren | req_rden;

   always_comb begin
      logic [2:0] v_idx;
      w_found = 1'b0;
      w_sel   = 3'd0;
      v_idx   = 3'd0;
      if (r_state == ST_LOCKED) begin
         if (w_req[r_owner]) begin
            w_found = 1'b1;
            w_sel   = r_owner;
         end
      end else begin
         // k = NUM_CORES wraps back to last_grant itself, which is lowest priority
         for (int k = 1; k <= NUM_CORES; k++) begin
            v_idx = (r_last_grant + 3'(k)) & IDX_MASK;
            if (!w_found && w_req[v_idx]) begin
               w_found = 1'b1;
               w_sel   = v_idx;
            end
         end
      end
   end

   always_comb begin
      grant         = '0;
      mem_wren      = 1'b0;
      mem_rden      = 1'b0;
      mem_addr      = '0;
      mem_write_val = '0;
      mem_core_id   = '0;
      w_sel_lock    = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (w_found && (w_sel == 3'(i))) begin
            grant[i]      = 1'b1;
            mem_wren      = req_wren[i];
            mem_rden      = req_rden[i] & ~req_wren[i];
            mem_addr      = req_addr[16*i +: 16];
            mem_write_val = req_write_val[16*i +: 16];
            mem_core_id   = w_sel;
            w_sel_lock    = req_lock[i];
         end
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_last_grant_nxt = r_last_grant;
      w_owner_nxt      = r_owner;
      w_lock_count_nxt = r_lock_count;
      w_no_relock_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_last_grant_nxt = w_sel;
               // an owner just evicted by the hold limit may not grab the lock again at once
               if (w_sel_lock && !(r_no_relock && (w_sel == r_owner))) begin
                  w_state_nxt      = ST_LOCKED;
                  w_owner_nxt      = w_sel;
                  w_lock_count_nxt = CW'(1);
               end
            end
         end
         ST_LOCKED: begin
            w_lock_count_nxt = r_lock_count + CW'(1);
            if (w_lock_count_nxt >= LOCK_MAX_C) begin
               w_state_nxt      = ST_IDLE;
               w_lock_count_nxt = '0;
               w_no_relock_nxt  = 1'b1;
            end else if (!req_lock[r_owner]) begin
               w_state_nxt      = ST_IDLE;
               w_lock_count_nxt = '0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_last_grant <= 3'(NUM_CORES - 1);
         r_owner      <= 3'd0;
         r_lock_count <= '0;
         r_no_relock  <= 1'b0;
         rd_valid     <= 1'b0;
         rd_core_id   <= 3'd0;
      end else begin
         r_state      <= w_state_nxt;
         r_last_grant <= w_last_grant_nxt;
         r_owner      <= w_owner_nxt;
         r_lock_count <= w_lock_count_nxt;
         r_no_relock  <= w_no_relock_nxt;
         rd_valid     <= mem_rden;
         if (mem_rden) begin
            rd_core_id <= mem_core_id;
         end
      end
   end

endmodule

// File: doc/remote_arbiter.md
REMOTE_ARBITER -- requirements
Module: remote_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 8, number of requesting cores (power of two, 2..8).
REQ-002 Parameter LOCK_MAX, default 16, maximum consecutive cycles one core may hold a lock.
REQ-003 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high; sampled on rising edge of clk.
REQ-005 Port req_wren, input, NUM_CORES, per-core write request.
REQ-006 Port req_rden, input, NUM_CORES, per-core read request.
REQ-007 Port req_lock, input, NUM_CORES, per-core request to keep the bus after the current grant.
REQ-008 Port req_addr, input, 16*NUM_CORES, per-core address; core i occupies bits [16i+15:16i].
REQ-009 Port req_write_val, input, 16*NUM_CORES, per-core write data, same packing as req_addr.
REQ-010 Port grant, output, NUM_CORES, one-hot or zero; combinational; core i's request is accepted in any cycle where grant[i]=1.
REQ-011 Port mem_wren / mem_rden, output, 1 each, strobes to the shared global-memory/device bus.
REQ-012 Port mem_addr / mem_write_val, output, 16 each, forwarded from the granted core.
REQ-013 Port mem_core_id, output, 3, index of the granted core.
REQ-014 Port rd_valid, output, 1, registered; read data on the shared bus is valid this cycle.
REQ-015 Port rd_core_id, output, 3, registered; destination core of the current read data.

Function
REQ-016 Core i is requesting when req_wren[i] or req_rden[i] is 1.
REQ-017 Unlocked arbitration: round-robin; search starts at index (last_grant+1) mod NUM_CORES, ascending with wrap; first requesting core is granted.
REQ-018 No requester: grant=0; mem_wren=mem_rden=0; mem_addr, mem_write_val and mem_core_id are 0; last_grant unchanged.
REQ-019 On every grant, last_grant is set to the granted index at the next edge.
REQ-020 Granted core: mem_addr, mem_write_val and mem_core_id follow that core in the same cycle (zero-latency mux).
REQ-021 If req_wren and req_rden are both 1 on the granted core, the write wins: mem_wren=1, mem_rden=0, no read return.
REQ-022 Read return: a cycle with mem_rden=1 produces rd_valid=1 and rd_core_id=mem_core_id exactly one cycle later; otherwise rd_valid=0 and rd_core_id holds its last value.
REQ-023 Back-to-back reads from different cores each return in order, one per cycle, with no bubble.
REQ-024 Lock states: IDLE and LOCKED. IDLE->LOCKED when the granted core has req_lock=1; the lock owner is recorded and lock_count is loaded with 1.
REQ-025 In LOCKED, only the owner may be granted; other requesters see grant=0 even when the owner is idle.
REQ-026 In LOCKED, lock_count increments on each cycle; LOCKED->IDLE after a cycle in which the owner is granted with req_lock=0, or the owner has no request and req_lock=0.
REQ-027 Forced release: when lock_count reaches LOCK_MAX, return to IDLE at that edge regardless of req_lock. The next arbitration starts at owner+1, and the owner cannot re-lock in that cycle.
REQ-028 last_grant is unchanged while LOCKED; on release it equals the owner.
REQ-029 No request is dropped: a core not granted holds its request, and the arbiter has no request storage.

Reset
REQ-030 On a reset edge: lock state=IDLE, lock_count=0, last_grant=NUM_CORES-1 (core 0 has first priority), rd_valid=0, rd_core_id=0.
REQ-031 Reset has priority over all events; a read issued in the reset cycle produces no rd_valid.
REQ-032 Combinational outputs depend only on inputs and registered state, with no extra reset gating.

Verification
REQ-033 After reset, all 8 cores assert req_rden continuously -> grant one-hot sequence 0,1,2,...,7,0; rd_valid=1 from cycle 2 on, with rd_core_id trailing mem_core_id by one cycle.
REQ-034 Only cores 2 and 5 write, last_grant=3 -> grant 5, then 2, then 5; mem_wren=1 every cycle; rd_valid stays 0.
REQ-035 Core 3 granted with req_lock=1 for 4 cycles while core 4 requests -> core 3 granted for 5 consecutive cycles, then core 4 granted the next cycle.
REQ-036 Core 1 holds req_lock=1 indefinitely with other cores requesting -> core 1 granted for exactly 16 cycles, then core 2 granted.
REQ-037 Core 6 asserts req_wren=1, req_rden=1, addr=16'hFC05 -> mem_wren=1, mem_rden=0, mem_addr=16'hFC05, no rd_valid next cycle.
REQ-038 Reset asserted mid-lock (owner 4, lock_count=7) -> next cycle IDLE, core 0 has first priority, rd_valid=0.
